// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer
//   Captures RVFI retirement records into a small FIFO and streams them to an
//   off-core trace sink over valid/ready. Records that arrive while the FIFO
//   is full and not draining are dropped. Each drop bumps a saturating
//   counter and sets a sticky overflow flag. The next accepted record is
//   tagged with a gap bit. A gap is also flagged when rvfi_order skips.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   rvfi_*                     retirement record from the core
//   trace_valid_o/ready_i      output stream handshake
//   trace_pc/insn/rd_*/mode_o  record payload (registered storage, FWFT)
//   trace_flags_o              {gap, intr, trap, mode[1]}
//   level_o                    occupancy
//   overflow_o, drop_cnt_o     loss reporting; clear_i resets both
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rvfi_valid,
    input  logic [63:0]                 rvfi_order,
    input  logic [31:0]                 rvfi_insn,
    input  logic                        rvfi_trap,
    input  logic                        rvfi_intr,
    input  logic [1:0]                  rvfi_mode,
    input  logic [4:0]                  rvfi_rd_addr,
    input  logic [31:0]                 rvfi_rd_wdata,
    input  logic [31:0]                 rvfi_pc_rdata,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [31:0]                 trace_pc_o,
    output logic [31:0]                 trace_insn_o,
    output logic [4:0]                  trace_rd_addr_o,
    output logic [31:0]                 trace_rd_wdata_o,
    output logic [3:0]                  trace_flags_o,
    output logic [1:0]                  trace_mode_o,
    output logic [$clog2(Depth+1)-1:0]  level_o,
    output logic                        overflow_o,
    output logic [DropCntWidth-1:0]     drop_cnt_o,
    input  logic                        clear_i
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    typedef struct packed {
        logic        gap;
        logic        intr;
        logic        trap;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] insn;
        logic [31:0] pc;
    } rec_t;

    rec_t                    mem_q [Depth];
    logic [PtrW-1:0]         wptr_q, rptr_q;
    logic [LvlW-1:0]         level_q, level_d;
    logic                    pending_gap_q, pending_gap_d;
    logic                    first_seen_q;
    logic [63:0]             last_order_q;
    logic                    overflow_q, overflow_d;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

    logic full, empty, push, pop, drop, gap_new;
    rec_t wr_rec, rd_rec;

    assign full  = (level_q == LvlW'(Depth));
    assign empty = (level_q == '0);
    assign pop   = !empty && trace_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = rvfi_valid && (!full || pop);
    assign drop  = rvfi_valid && full && !pop;

    // The order check runs against the last order seen, dropped or not, so
    // a lone drop flags exactly one gap (via pending_gap), not two.
    assign gap_new = pending_gap_q ||
                     (first_seen_q && (rvfi_order != last_order_q + 64'd1));

    always_comb begin
        wr_rec          = '0;
        wr_rec.gap      = gap_new;
        wr_rec.intr     = rvfi_intr;
        wr_rec.trap     = rvfi_trap;
        wr_rec.mode     = rvfi_mode;
        wr_rec.rd_addr  = rvfi_rd_addr;
        wr_rec.rd_wdata = rvfi_rd_wdata;
        wr_rec.insn     = rvfi_insn;
        wr_rec.pc       = rvfi_pc_rdata;
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        pending_gap_d = pending_gap_q;
        if (drop)      pending_gap_d = 1'b1;
        else if (push) pending_gap_d = 1'b0;

        // Clear takes priority, then a same-cycle drop is counted on top.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            overflow_d = drop;
            drop_cnt_d = drop ? DropCntWidth'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            level_q       <= '0;
            pending_gap_q <= 1'b0;
            first_seen_q  <= 1'b0;
            last_order_q  <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_rec;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop) rptr_q <= rptr_q + PtrW'(1);
            if (rvfi_valid) begin
                first_seen_q <= 1'b1;
                last_order_q <= rvfi_order;
            end
            level_q       <= level_d;
            pending_gap_q <= pending_gap_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign rd_rec           = mem_q[rptr_q];
    assign trace_valid_o    = !empty;
    assign trace_pc_o       = rd_rec.pc;
    assign trace_insn_o     = rd_rec.insn;
    assign trace_rd_addr_o  = rd_rec.rd_addr;
    assign trace_rd_wdata_o = rd_rec.rd_wdata;
    assign trace_mode_o     = rd_rec.mode;
    assign trace_flags_o    = {rd_rec.gap, rd_rec.intr, rd_rec.trap, rd_rec.mode[1]};
    assign level_o          = level_q;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
module tb_ibex_rvfi_trace_buffer;
    localparam int DEPTH = 8;
    localparam int DCW   = 2;
    localparam int DMAX  = (1 << DCW) - 1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_insn_o;
    logic [4:0]  trace_rd_addr_o;
    logic [31:0] trace_rd_wdata_o;
    logic [3:0]  trace_flags_o;
    logic [1:0]  trace_mode_o;
    logic [$clog2(DEPTH+1)-1:0] level_o;
    logic        overflow_o;
    logic [DCW-1:0] drop_cnt_o;
    logic        clear_i;

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntWidth(DCW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
        .trace_rd_addr_o(trace_rd_addr_o), .trace_rd_wdata_o(trace_rd_wdata_o),
        .trace_flags_o(trace_flags_o), .trace_mode_o(trace_mode_o),
        .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .clear_i(clear_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc, insn, wdata;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic        trap, intr, gap;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    // reference model state
    int          cnt, dcnt;
    bit          ovf, pg, fs;
    logic [63:0] last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cnt = 0; dcnt = 0; ovf = 0; pg = 0; fs = 0; last = '0;
    endtask

    // One cycle: drive inputs, advance the model, then check the
    // registered status outputs just after the edge.
    task automatic step(input bit v, input logic [63:0] ord, input bit rdy,
                        input bit clr, input logic [31:0] pc, input logic [31:0] insn);
        exp_t e;
        bit pop, push, drop, full;
        rvfi_valid    = v;
        rvfi_order    = ord;
        rvfi_insn     = insn;
        rvfi_pc_rdata = pc;
        rvfi_trap     = 1'($urandom);
        rvfi_intr     = 1'($urandom);
        rvfi_mode     = 2'($urandom);
        rvfi_rd_addr  = 5'($urandom);
        rvfi_rd_wdata = $urandom;
        trace_ready_i = rdy;
        clear_i       = clr;
        full = (cnt == DEPTH);
        pop  = (cnt > 0) && rdy;
        push = v && (!full || pop);
        drop = v && full && !pop;
        if (push) begin
            e.pc = pc; e.insn = insn; e.wdata = rvfi_rd_wdata; e.rd = rvfi_rd_addr;
            e.mode = rvfi_mode; e.trap = rvfi_trap; e.intr = rvfi_intr;
            e.gap = pg || (fs && ord != last + 64'd1);
            pg = 0;
            sb.push_back(e);
        end
        if (drop) pg = 1;
        if (clr) begin
            dcnt = drop ? 1 : 0;
            ovf  = drop;
        end else if (drop) begin
            if (dcnt < DMAX) dcnt++;
            ovf = 1;
        end
        if (v) begin fs = 1; last = ord; end
        cnt = cnt + int'(push) - int'(pop);
        @(posedge clk_i); #1;
        chk("level", 64'(level_o), 64'(cnt));
        chk("valid", 64'(trace_valid_o), 64'(cnt > 0));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(dcnt));
        chk("overflow", 64'(overflow_o), 64'(ovf));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, rdy, 0, $urandom, $urandom);
    endtask

    // Monitor: whenever a record is presented, it must match the scoreboard
    // head; the head is retired only when the sink accepts it.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && trace_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_record", 64'(trace_pc_o), 64'hdead);
            end else begin
                chk("pc", 64'(trace_pc_o), 64'(sb[0].pc));
                chk("insn", 64'(trace_insn_o), 64'(sb[0].insn));
                chk("rd_addr", 64'(trace_rd_addr_o), 64'(sb[0].rd));
                chk("rd_wdata", 64'(trace_rd_wdata_o), 64'(sb[0].wdata));
                chk("mode", 64'(trace_mode_o), 64'(sb[0].mode));
                chk("flags", 64'(trace_flags_o),
                    64'({sb[0].gap, sb[0].intr, sb[0].trap, sb[0].mode[1]}));
                if (trace_ready_i === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] o;
        rst_ni = 1'b0; rvfi_valid = 0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = 0;
        rvfi_intr = 0; rvfi_mode = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
        rvfi_pc_rdata = '0; trace_ready_i = 0; clear_i = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(trace_valid_o), 0);
        chk("rst_level", 64'(level_o), 0);
        chk("rst_pc", 64'(trace_pc_o), 0);
        chk("rst_flags", 64'(trace_flags_o), 0);
        chk("rst_drop", 64'(drop_cnt_o), 0);
        chk("rst_ovf", 64'(overflow_o), 0);
        rst_ni = 1'b1;

        // single retire
        step(1, 64'd0, 1, 0, 32'h100, 32'h13);
        idle(2, 1);

        // backpressure fill: 9 retires into 8 entries, then drain, then a
        // retire carrying the pending gap
        for (int i = 1; i <= 9; i++) step(1, 64'(i), 0, 0, $urandom, $urandom);
        chk("fill_level", 64'(level_o), 8);
        chk("fill_drop", 64'(drop_cnt_o), 1);
        idle(9, 1);
        step(1, 64'd10, 1, 0, $urandom, $urandom);
        idle(2, 1);

        // full with simultaneous push/pop
        for (int i = 11; i <= 18; i++) step(1, 64'(i), 0, 0, $urandom, $urandom);
        for (int i = 19; i < 39; i++) step(1, 64'(i), 1, 0, $urandom, $urandom);
        chk("fullpp_level", 64'(level_o), 8);
        idle(10, 1);

        // order discontinuity
        step(1, 64'd5, 1, 0, $urandom, $urandom);
        step(1, 64'd7, 1, 0, $urandom, $urandom);
        idle(3, 1);

        // saturation and clear
        for (int i = 0; i < 13; i++) step(1, 64'(100 + i), 0, 0, $urandom, $urandom);
        chk("sat_drop", 64'(drop_cnt_o), 3);
        step(0, '0, 0, 1, $urandom, $urandom);
        step(1, 64'd113, 0, 1, $urandom, $urandom);
        chk("clr_drop", 64'(drop_cnt_o), 1);
        idle(10, 1);

        // randomized traffic, order wrap included
        o = 64'hFFFF_FFFF_FFFF_FFF0;
        for (int i = 0; i < 400; i++) begin
            bit v;
            v = ($urandom % 4) != 0;
            if (v) o = (($urandom % 8) == 0) ? o + 64'($urandom % 5) : o + 64'd1;
            step(v, o, ($urandom % 3) != 0, ($urandom % 25) == 0, $urandom, $urandom);
        end
        idle(10, 1);
        chk("sb_drained", 64'(sb.size()), 0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) step(1, 64'(200 + i), 0, 0, $urandom, $urandom);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(trace_valid_o), 0);
        chk("mid_rst_level", 64'(level_o), 0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        step(1, 64'd500, 1, 0, $urandom, $urandom);
        idle(3, 1);
        chk("final_drained", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
